prog_clk_divider: RTL and testbench

//   Multi-channel, runtime-programmable successor to the fixed single-output divider.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_channel.sv | 74 +++++++
 rtl/prog_clk_divider.sv | 56 +++++
 tb/tb_prog_clk_divider.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types for the programmable clock divider: channel mode and config request.
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_e;

    localparam int DIV_MIN   = 1;
    // Request divisor is carried at a fixed width; channels use the low CNT_W bits (CNT_W <= 32).
    localparam int CFG_DIV_W = 32;

    typedef struct packed {
        logic [CFG_DIV_W-1:0] div;
        div_mode_e            mode;
    } div_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow config, pending flag and registered outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 16,
    parameter bit DEFAULT_MODE = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     cfg_we,
    input  div_cfg_t cfg,
    output logic     div_out,
    output logic     tick,
    output logic     pending
);
    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
    localparam div_mode_e        RST_MODE = div_mode_e'(DEFAULT_MODE);

    logic [CNT_W-1:0] cnt, act_div, sh_div, cfg_div_c;
    div_mode_e        act_mode, sh_mode;
    logic             term, apply;

    assign term      = (cnt == act_div - CNT_W'(1));
    // Shadow only moves to active at a period boundary, so the running period is never cut.
    assign apply     = pending && (!en || term);
    assign cfg_div_c = (cfg.div == '0) ? CNT_W'(DIV_MIN) : cfg.div[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            tick     <= 1'b0;
            div_out  <= 1'b0;
            pending  <= 1'b0;
            act_div  <= RST_DIV;
            act_mode <= RST_MODE;
            sh_div   <= RST_DIV;
            sh_mode  <= RST_MODE;
        end else begin
            if (en) begin
                if (term) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    if (act_mode == MODE_TOGGLE)
                        div_out <= ~div_out;
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    tick <= 1'b0;
                end
            end else begin
                cnt     <= '0;
                tick    <= 1'b0;
                div_out <= 1'b0;
            end

            if (apply) begin
                act_div  <= sh_div;
                act_mode <= sh_mode;
                pending  <= 1'b0;
                if (sh_mode != act_mode)
                    div_out <= 1'b0;
            end

            // Accept is gated by ~pending, so it never collides with apply on the same edge.
            if (cfg_we) begin
                sh_div  <= cfg_div_c;
                sh_mode <= cfg.mode;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: config decode and ready mux around per-channel dividers.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 16,
    parameter bit DEFAULT_MODE = 1'b0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    div_cfg_t          req;
    logic [NUM_CH-1:0] cfg_we;

    assign req.div  = CFG_DIV_W'(cfg_div);
    assign req.mode = div_mode_e'(cfg_mode);

    // Out-of-range channels stay ready so the request drains without effect.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i))
                cfg_ready = ~pending[i];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign cfg_we[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clk_div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[g]),
            .cfg_we  (cfg_we[g]),
            .cfg     (req),
            .div_out (div_out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: per-cycle scoreboard plus config table and corner-case sequences.
module tb_prog_clk_divider;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_ch = '0;
    logic [15:0]  cfg_div = '0;
    logic         cfg_mode = 1'b0;
    logic [N-1:0] ch_en = '1;
    logic [N-1:0] div_out, tick, pending;

    // Three-channel instance so an out-of-range cfg_ch fits the select width.
    logic         v3 = 1'b0;
    logic         r3;
    logic [1:0]   c3 = 2'd3;
    logic [7:0]   d3 = 8'd2;
    logic         m3 = 1'b0;
    logic [2:0]   en3 = '1;
    logic [2:0]   o3, t3, p3;

    always #5 clk = ~clk;

    prog_clk_divider #(.NUM_CH(N), .CNT_W(16), .DEFAULT_DIV(16), .DEFAULT_MODE(1'b0)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .ch_en(ch_en), .div_out(div_out),
        .tick(tick), .pending(pending)
    );

    prog_clk_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4), .DEFAULT_MODE(1'b0)) dut3 (
        .clk(clk), .rst(rst), .cfg_valid(v3), .cfg_ready(r3), .cfg_ch(c3),
        .cfg_div(d3), .cfg_mode(m3), .ch_en(en3), .div_out(o3),
        .tick(t3), .pending(p3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model of the channel behaviour
    int m_cnt[N], m_div[N], m_sdiv[N];
    bit m_mode[N], m_smode[N], m_pend[N], m_out[N], m_tick[N];

    typedef struct {
        logic [N-1:0] tick;
        logic [N-1:0] out;
        logic [N-1:0] pend;
    } exp_t;
    exp_t sbq[$];

    int cycn;
    int last_t[N], gap[N], last_r[N], ogap[N];
    bit prev_o[N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_cnt[c] = 0; m_div[c] = 16; m_sdiv[c] = 16;
            m_mode[c] = 0; m_smode[c] = 0; m_pend[c] = 0; m_out[c] = 0; m_tick[c] = 0;
            last_t[c] = -1; gap[c] = 0; last_r[c] = -1; ogap[c] = 0; prev_o[c] = 0;
        end
        sbq.delete();
    endtask

    task automatic model_step(output exp_t e);
        for (int c = 0; c < N; c++) begin
            bit term, apply, acc;
            term  = (m_cnt[c] == m_div[c] - 1);
            apply = m_pend[c] && (!ch_en[c] || term);
            acc   = cfg_valid && !m_pend[c] && (int'(cfg_ch) == c);
            if (ch_en[c]) begin
                if (term) begin
                    m_cnt[c] = 0; m_tick[c] = 1;
                    if (!m_mode[c]) m_out[c] = !m_out[c];
                end else begin
                    m_cnt[c]++; m_tick[c] = 0;
                end
            end else begin
                m_cnt[c] = 0; m_tick[c] = 0; m_out[c] = 0;
            end
            if (apply) begin
                if (m_smode[c] != m_mode[c]) m_out[c] = 0;
                m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 0;
            end
            if (acc) begin
                m_sdiv[c] = (cfg_div == 0) ? 1 : int'(cfg_div);
                m_smode[c] = cfg_mode; m_pend[c] = 1;
            end
            e.tick[c] = m_tick[c]; e.out[c] = m_out[c]; e.pend[c] = m_pend[c];
        end
    endtask

    // One clock: inputs are already driven; expectation queued, DUT compared after the edge.
    task automatic cyc();
        exp_t e;
        if (cfg_valid) chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
        model_step(e);
        sbq.push_back(e);
        @(posedge clk); #1;
        cycn++;
        e = sbq.pop_front();
        chk("sb_tick", 32'(tick), 32'(e.tick));
        chk("sb_div_out", 32'(div_out), 32'(e.out));
        chk("sb_pending", 32'(pending), 32'(e.pend));
        for (int c = 0; c < N; c++) begin
            if (tick[c]) begin
                if (last_t[c] >= 0) gap[c] = cycn - last_t[c];
                last_t[c] = cycn;
            end
            if (div_out[c] && !prev_o[c]) begin
                if (last_r[c] >= 0) ogap[c] = cycn - last_r[c];
                last_r[c] = cycn;
            end
            prev_o[c] = div_out[c];
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Present a request, wait (bounded) for ready, transfer it, then drop valid.
    task automatic issue(input int ch, input int dv, input bit md);
        int n;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 16'(dv); cfg_mode = md;
        n = 0;
        while (m_pend[ch] && n < 100) begin cyc(); n++; end
        if (n == 100) chk("cfg_wait_timeout", 32'(n), 32'(0));
        cyc();
        cfg_valid = 1'b0;
        chk("pending_after_accept", 32'(pending[ch]), 32'(1));
    endtask

    typedef struct {
        int ch; int dv; bit md; int pre; int rn; int exp_gap; int exp_ogap;
    } vec_t;
    vec_t tbl[4];

    initial begin
        int n, k, cnt3;

        tbl[0] = '{1, 3, 1'b0, 3, 40, 3, 6};
        tbl[1] = '{3, 0, 1'b0, 0, 40, 1, 2};
        tbl[2] = '{0, 1, 1'b0, 0, 40, 1, 2};
        tbl[3] = '{2, 5, 1'b1, 0, 40, 5, -1};

        model_reset();
        cycn = 0;
        #3;
        chk("rst_div_out", 32'(div_out), 32'(0));
        chk("rst_tick", 32'(tick), 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("rst3_outputs", 32'({o3, t3, p3}), 32'(0));
        @(negedge clk);
        rst = 1'b1;

        // Defaults: D=16 toggle on every channel
        run(50);
        for (int c = 0; c < N; c++) begin
            chk("default_tick_gap", 32'(gap[c]), 32'(16));
            chk("default_out_period", 32'(ogap[c]), 32'(32));
        end

        for (int v = 0; v < 4; v++) begin
            run(tbl[v].pre);
            issue(tbl[v].ch, tbl[v].dv, tbl[v].md);
            run(tbl[v].rn);
            chk("tbl_tick_gap", 32'(gap[tbl[v].ch]), 32'(tbl[v].exp_gap));
            if (tbl[v].exp_ogap > 0)
                chk("tbl_out_period", 32'(ogap[tbl[v].ch]), 32'(tbl[v].exp_ogap));
            else
                chk("tbl_pulse_out_low", 32'(div_out[tbl[v].ch]), 32'(0));
        end

        // PULSE ch2: disable two cycles, then first tick exactly D=5 edges after re-enable
        ch_en[2] = 1'b0;
        run(2);
        chk("dis_tick_low", 32'(tick[2]), 32'(0));
        chk("dis_out_low", 32'(div_out[2]), 32'(0));
        ch_en[2] = 1'b1;
        k = 0;
        do begin cyc(); k++; end while (!tick[2] && k < 20);
        chk("reenable_first_tick", 32'(k), 32'(5));

        // Back-to-back on ch2: second request stalls until the first applies
        issue(2, 7, 1'b0);
        cfg_valid = 1'b1; cfg_div = 16'd9;
        chk("b2b_ready_low", 32'(cfg_ready), 32'(0));
        n = 0;
        while (m_pend[2] && n < 100) begin cyc(); n++; end
        cyc();
        cfg_valid = 1'b0;
        run(20);
        chk("b2b_tick_gap", 32'(gap[2]), 32'(9));

        // Accept on the terminal-count edge defers apply by one full period
        n = 0;
        while (!(m_cnt[2] == 8 && m_div[2] == 9 && !m_pend[2]) && n < 100) begin cyc(); n++; end
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd4; cfg_mode = 1'b0;
        cyc();
        cfg_valid = 1'b0;
        k = 0;
        do begin cyc(); k++; end while (pending[2] && k < 50);
        chk("term_accept_defer", 32'(k), 32'(9));
        run(20);
        chk("term_accept_gap", 32'(gap[2]), 32'(4));

        // Disabled channel applies on the very next edge
        ch_en[3] = 1'b0;
        cyc();
        issue(3, 2, 1'b0);
        cyc();
        chk("dis_apply_next_edge", 32'(pending[3]), 32'(0));
        ch_en[3] = 1'b1;
        run(10);
        chk("dis_apply_gap", 32'(gap[3]), 32'(2));

        // Out-of-range channel: ready, no state change, divider unaffected
        v3 = 1'b1;
        #1;
        chk("oor_ready", 32'(r3), 32'(1));
        cyc();
        v3 = 1'b0;
        chk("oor_pending", 32'(p3), 32'(0));
        cnt3 = 0;
        for (int i = 0; i < 20; i++) begin cyc(); cnt3 += int'(t3[0]); end
        chk("oor_tick_count", 32'(cnt3), 32'(5));

        // Async reset mid-period with ch1 pending
        issue(1, 10, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_div_out", 32'(div_out), 32'(0));
        chk("async_rst_tick", 32'(tick), 32'(0));
        chk("async_rst_pending", 32'(pending), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run(70);
        chk("post_rst_gap_ch1", 32'(gap[1]), 32'(16));
        chk("post_rst_out_ch1", 32'(ogap[1]), 32'(32));
        chk("post_rst_gap_ch0", 32'(gap[0]), 32'(16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
